// File: rtl/matmul_z_drain.sv
// ---------------------------------------------------------------------------
// matmul_z_drain
//
// Purpose:
//   Downstream stage of matmul_top. Once matmul_top signals that the result
//   memory Z is complete, this block reads all MATRIX_SIZE words of Z in
//   address order and streams them out on a valid/ready interface, tagging
//   the final word with m_last. A 2-entry output buffer absorbs the 1-cycle
//   memory read latency and any downstream backpressure, so no word is lost
//   or duplicated.
//
// Ports:
//   clock       in   single clock, all logic on the rising edge
//   reset       in   synchronous, active-high reset
//   done        in   level from matmul_top, high when Z is complete
//   z_rd_addr   out  Z read address; data returns on z_dout one cycle later
//   z_dout      in   Z read data
//   m_data      out  stream data (head of the output buffer)
//   m_valid     out  stream valid (output buffer not empty)
//   m_ready     in   stream ready; a beat transfers on m_valid && m_ready
//   m_last      out  high with the final beat (index MATRIX_SIZE-1)
//   busy        out  high while a drain is in progress
//   drain_done  out  one-cycle pulse after the last beat transfers
// ---------------------------------------------------------------------------
module matmul_z_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int MATRIX_SIZE = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  drain_done
);

    // Counters carry one extra bit so they can hold MATRIX_SIZE itself even
    // when MATRIX_SIZE equals 2**ADDR_WIDTH.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] SIZE_C     = CW'(MATRIX_SIZE);
    localparam logic [CW-1:0] LAST_IDX_C = CW'(MATRIX_SIZE - 1);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [CW-1:0]         rdCnt_q,     rdCnt_d;
    logic [CW-1:0]         beatCnt_q,   beatCnt_d;
    logic                  inFlight_q,  inFlight_d;
    logic [1:0]            count_q,     count_d;
    logic                  wrPtr_q,     wrPtr_d;
    logic                  rdPtr_q,     rdPtr_d;
    logic [DATA_WIDTH-1:0] buf0_q,      buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q,      buf1_d;
    logic                  drainDone_q, drainDone_d;

    logic pop;
    logic push;
    logic credit;
    logic issue;
    logic lastXfer;

    // Output view of the buffer and FSM. m_data is forced to zero while the
    // buffer is empty so idle and reset states present a clean bus.
    always_comb begin
        m_valid    = (count_q != 2'd0);
        m_data     = '0;
        if (m_valid) begin
            m_data = rdPtr_q ? buf1_q : buf0_q;
        end
        m_last     = m_valid && (beatCnt_q == LAST_IDX_C);
        busy       = (state_q == DRAIN);
        drain_done = drainDone_q;
        z_rd_addr  = rdCnt_q[ADDR_WIDTH-1:0];
    end

    // Credit check: words already buffered plus the word returning from
    // memory, minus the word leaving this cycle, must leave room for one
    // more. This is what keeps the 2-entry buffer from ever overflowing.
    always_comb begin
        pop      = m_valid && m_ready;
        push     = inFlight_q;
        credit   = ({1'b0, count_q} + {2'b00, inFlight_q}) < (3'd2 + {2'b00, pop});
        issue    = (state_q == DRAIN) && (rdCnt_q < SIZE_C) && credit;
        lastXfer = pop && m_last;
    end

    // Drain sequencing. Counters are cleared on the final transfer so that
    // z_rd_addr rests at zero outside a drain and the next drain starts
    // from address 0. HOLD waits for done to drop so a level-held done
    // cannot retrigger.
    always_comb begin
        state_d     = state_q;
        rdCnt_d     = rdCnt_q;
        beatCnt_d   = beatCnt_q;
        inFlight_d  = issue;
        drainDone_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (issue) begin
                    rdCnt_d = rdCnt_q + ONE_C;
                end
                if (lastXfer) begin
                    state_d     = HOLD;
                    rdCnt_d     = '0;
                    beatCnt_d   = '0;
                    drainDone_d = 1'b1;
                end else if (pop) begin
                    beatCnt_d = beatCnt_q + ONE_C;
                end
            end
            HOLD: begin
                if (!done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Two-entry FIFO with separate write and read pointers; a push and a
    // pop in the same cycle leave the occupancy unchanged.
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            if (wrPtr_q) begin
                buf1_d = z_dout;
            end else begin
                buf0_d = z_dout;
            end
            wrPtr_d = ~wrPtr_q;
        end
        if (pop) begin
            rdPtr_d = ~rdPtr_q;
        end
    end

    // State registers; reset discards any buffered or in-flight words.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rdCnt_q     <= '0;
            beatCnt_q   <= '0;
            inFlight_q  <= 1'b0;
            count_q     <= 2'd0;
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            drainDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdCnt_q     <= rdCnt_d;
            beatCnt_q   <= beatCnt_d;
            inFlight_q  <= inFlight_d;
            count_q     <= count_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            drainDone_q <= drainDone_d;
        end
    end

endmodule

// File: tb/tb_matmul_z_drain.sv
// ---------------------------------------------------------------------------
// tb_matmul_z_drain
//
// Purpose:
//   Testbench for matmul_z_drain. Two instances are used: a 64-word drain
//   and a 2-word drain. A memory model returns Z one cycle after the
//   address. Each drain pushes the list of words it should produce into a
//   queue; monitor processes pop and compare on every transfer.
// ---------------------------------------------------------------------------
module tb_matmul_z_drain;

    localparam int N  = 64;
    localparam int N2 = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clock;
    logic        reset;
    logic        done;
    logic [9:0]  zRdAddr;
    logic [31:0] zDout;
    logic [31:0] mData;
    logic        mValid;
    logic        mReady;
    logic        mLast;
    logic        busy;
    logic        drainDone;

    logic        done2;
    logic [1:0]  zRdAddr2;
    logic [31:0] zDout2;
    logic [31:0] mData2;
    logic        mValid2;
    logic        mReady2;
    logic        mLast2;
    logic        busy2;
    logic        drainDone2;

    logic [31:0] zMem  [0:N-1];
    logic [31:0] zMem2 [0:3];

    beat_t expQ  [$];
    beat_t expQ2 [$];

    int tests;
    int fails;
    int readyMode;
    int accepted;
    int drainDone2Count;

    logic        stallHeld;
    logic [31:0] stallData;
    logic        stallLast;

    matmul_z_drain #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .MATRIX_SIZE(N)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .done      (done),
        .z_rd_addr (zRdAddr),
        .z_dout    (zDout),
        .m_data    (mData),
        .m_valid   (mValid),
        .m_ready   (mReady),
        .m_last    (mLast),
        .busy      (busy),
        .drain_done(drainDone)
    );

    matmul_z_drain #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (2),
        .MATRIX_SIZE(N2)
    ) dut2 (
        .clock     (clock),
        .reset     (reset),
        .done      (done2),
        .z_rd_addr (zRdAddr2),
        .z_dout    (zDout2),
        .m_data    (mData2),
        .m_valid   (mValid2),
        .m_ready   (mReady2),
        .m_last    (mLast2),
        .busy      (busy2),
        .drain_done(drainDone2)
    );

    // 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous-read memory models for Z
    always @(posedge clock) begin
        zDout  <= zMem[zRdAddr[5:0]];
        zDout2 <= zMem2[zRdAddr2];
    end

    // Ready drivers: mode 0 always ready, 1 toggling, 2 ~30% low, 3 held low
    initial begin
        mReady  = 1'b1;
        mReady2 = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (readyMode)
                0:       mReady = 1'b1;
                1:       mReady = ~mReady;
                2:       mReady = ($urandom_range(0, 9) >= 3);
                default: mReady = 1'b0;
            endcase
            mReady2 = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pushDrain();
        for (int i = 0; i < N; i++) begin
            expQ.push_back('{data: zMem[i], last: (i == N - 1)});
        end
    endtask

    task automatic waitDrainDone(input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (drainDone) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, seen, 1);
    endtask

    task automatic endDrain();
        tick();
        done = 1'b0;
        tick();
        tick();
    endtask

    // Monitor for the 64-word instance: scoreboard, stall stability,
    // read-ahead bound and end-of-drain consistency.
    initial begin
        beat_t e;
        int    ahead;
        stallHeld = 1'b0;
        stallData = '0;
        stallLast = 1'b0;
        accepted  = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stallHeld = 1'b0;
                accepted  = 0;
            end else begin
                if (stallHeld) begin
                    checkOutput("stall_valid", mValid, 1);
                    checkOutput("stall_data", mData, stallData);
                    checkOutput("stall_last", mLast, stallLast);
                end
                if (busy) begin
                    ahead = int'(zRdAddr) - accepted;
                    checkOutput("read_ahead", (ahead <= 2), 1);
                end
                if (mValid && mReady) begin
                    if (expQ.size() == 0) begin
                        checkOutput("extra_beat", mData, 32'hDEAD_BEEF);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beat_data", mData, e.data);
                        checkOutput("beat_last", mLast, e.last);
                    end
                    accepted++;
                end
                stallHeld = mValid && !mReady;
                stallData = mData;
                stallLast = mLast;
                if (drainDone) begin
                    checkOutput("done_queue_empty", (expQ.size() == 0), 1);
                    checkOutput("done_busy_low", busy, 0);
                    accepted = 0;
                end
            end
        end
    end

    // Monitor for the 2-word instance
    initial begin
        beat_t e;
        drainDone2Count = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (mValid2 && mReady2) begin
                    if (expQ2.size() == 0) begin
                        checkOutput("n2_extra_beat", mData2, 32'hDEAD_BEEF);
                    end else begin
                        e = expQ2.pop_front();
                        checkOutput("n2_beat_data", mData2, e.data);
                        checkOutput("n2_beat_last", mLast2, e.last);
                    end
                end
                if (drainDone2) begin
                    drainDone2Count++;
                end
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus();
        int  cnt;
        logic seen;

        // Reset state
        reset     = 1'b1;
        done      = 1'b0;
        done2     = 1'b0;
        readyMode = 0;
        for (int i = 0; i < N; i++) zMem[i] = 32'(3 * i + 1);
        for (int i = 0; i < 4; i++) zMem2[i] = 32'hFFFF_FFFF - 32'(i);
        tick();
        tick();
        @(negedge clock);
        checkOutput("rst_addr", {22'd0, zRdAddr}, 0);
        checkOutput("rst_valid", mValid, 0);
        checkOutput("rst_last", mLast, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_drain_done", drainDone, 0);
        checkOutput("rst_data", mData, 0);
        checkOutput("rst_valid2", mValid2, 0);
        tick();
        reset = 1'b0;
        tick();

        // Test 1: full-rate drain with exact cycle timing
        $display("[TB] test 1: full-rate drain");
        pushDrain();
        done = 1'b1;
        for (int k = 0; k <= 68; k++) begin
            @(negedge clock);
            checkOutput("t1_valid_timing", mValid, ((k >= 3) && (k <= N + 2)));
            checkOutput("t1_busy_timing", busy, ((k >= 1) && (k <= N + 2)));
            checkOutput("t1_done_timing", drainDone, (k == N + 3));
            if (k == 1) checkOutput("t1_first_addr", {22'd0, zRdAddr}, 0);
        end
        endDrain();

        // Test 2: toggling then random backpressure
        $display("[TB] test 2: backpressure");
        for (int i = 0; i < N; i++) zMem[i] = 32'(i);
        readyMode = 1;
        tick();
        pushDrain();
        done = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        readyMode = 2;
        waitDrainDone(2000, "t2_drain_done");
        endDrain();

        // Test 3: long stall right after done
        $display("[TB] test 3: initial stall");
        for (int i = 0; i < N; i++) zMem[i] = 32'(5 * i + 7);
        readyMode = 3;
        tick();
        tick();
        pushDrain();
        done = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clock);
            if (k >= 3) begin
                checkOutput("t3_addr_held", {22'd0, zRdAddr}, 2);
                checkOutput("t3_valid_held", mValid, 1);
                checkOutput("t3_data_held", mData, zMem[0]);
            end
        end
        tick();
        readyMode = 0;
        waitDrainDone(500, "t3_drain_done");
        endDrain();

        // Test 4: level-held done must not retrigger
        $display("[TB] test 4: held done");
        for (int i = 0; i < N; i++) zMem[i] = 32'h0A00_0000 + 32'(i * 3);
        readyMode = 2;
        tick();
        pushDrain();
        done = 1'b1;
        waitDrainDone(1000, "t4_first_done");
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            checkOutput("t4_no_retrigger_valid", mValid, 0);
            checkOutput("t4_no_retrigger_busy", busy, 0);
        end
        tick();
        done = 1'b0;
        tick();
        done = 1'b1;
        pushDrain();
        waitDrainDone(1000, "t4_second_done");
        endDrain();

        // Test 5: reset after beat 30, done kept high
        $display("[TB] test 5: reset mid-drain");
        for (int i = 0; i < N; i++) zMem[i] = 32'h1000_0000 + 32'(i * i);
        readyMode = 0;
        tick();
        pushDrain();
        done = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (mValid && mReady) cnt++;
            if (cnt == 31) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t5_reach_beat30", seen, 1);
        tick();
        reset = 1'b1;
        expQ.delete();
        tick();
        reset = 1'b0;
        pushDrain();
        @(negedge clock);
        checkOutput("t5_valid_after_reset", mValid, 0);
        waitDrainDone(500, "t5_drain_done");
        endDrain();

        // Test 6: two-word drain with random ready
        $display("[TB] test 6: two-word drain");
        expQ2.push_back('{data: zMem2[0], last: 1'b0});
        expQ2.push_back('{data: zMem2[1], last: 1'b1});
        done2 = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (drainDone2) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t6_drain_done", seen, 1);
        for (int k = 0; k < 20; k++) tick();
        checkOutput("t6_done_pulses", drainDone2Count, 1);
        checkOutput("t6_queue_empty", (expQ2.size() == 0), 1);
        done2 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matmul_z_drain.md
Name: matmul_z_drain

Overview:
- Downstream stage of matmul_top. When matmul_top raises done, this block reads the result memory Z (MATRIX_SIZE words) through z_rd_addr/z_dout.
- It emits the words in address order on a valid/ready output stream, and tags the final word with m_last.
- A 2-entry output buffer absorbs the 1-cycle memory read latency and downstream backpressure with no lost or duplicated words.

Parameters:
DATA_WIDTH, 32, width of Z words and m_data
ADDR_WIDTH, 10, width of z_rd_addr
MATRIX_SIZE, 64, number of Z words per drain (must be >=2 and <=2**ADDR_WIDTH)

Ports:
clock  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
done  input  1  level from matmul_top; high when Z is complete
z_rd_addr  output  ADDR_WIDTH  Z read address; z_dout in cycle t+1 is the data at z_rd_addr in cycle t
z_dout  input  DATA_WIDTH  Z read data
m_data  output  DATA_WIDTH  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready; a beat transfers when m_valid && m_ready
m_last  output  1  high with the final beat (index MATRIX_SIZE-1)
busy  output  1  high while in DRAIN
drain_done  output  1  one-cycle pulse after the last beat transfers

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE; read counter, beat counter, buffer count and in-flight flag cleared.
  - Outputs: z_rd_addr=0, m_valid=0, m_last=0, busy=0, drain_done=0, m_data=0.
- States: IDLE, DRAIN, HOLD.
  - IDLE->DRAIN when done is sampled high.
  - DRAIN->HOLD on the clock edge that transfers beat MATRIX_SIZE-1; drain_done=1 for exactly the following cycle.
  - HOLD->IDLE when done is sampled low. A level-held done therefore never retriggers a drain.
- Read issue, in DRAIN only:
  - z_rd_addr = read counter (registered).
  - A read issues in a cycle when read counter < MATRIX_SIZE and (buffer count + in-flight - pop) < 2, where pop = m_valid && m_ready in that cycle.
  - On issue: the read counter increments at the edge and the in-flight flag sets.
  - When no read issues, the counter holds and in-flight clears.
  - At most one read per cycle.
- Capture: if in-flight was set during a cycle, z_dout in the following cycle is pushed into the buffer at that cycle's edge.
- Output buffer: 2-entry FIFO.
  - m_valid = buffer not empty.
  - m_data = head entry.
  - Simultaneous push and pop in one cycle is allowed.
  - Overflow cannot occur under the credit rule above.
- Stall: while m_valid && !m_ready, m_data and m_last stay stable.
- m_last = m_valid && (beat counter == MATRIX_SIZE-1). The beat counter increments on each transfer.
- Latency: with done first sampled high at cycle 0, z_rd_addr=0 is issued in cycle 1 and m_valid rises in cycle 3.
- Throughput: with m_ready held high, one beat per cycle. Beats occupy cycles 3..MATRIX_SIZE+2, and drain_done pulses in cycle MATRIX_SIZE+3.
- Read-ahead bound: z_rd_addr never runs more than 2 words ahead of the next beat to transfer.
- busy=1 exactly while state==DRAIN.
- done deasserting during DRAIN is ignored; the drain completes.
- Reset mid-drain: the buffer is discarded and no further beats are produced. If done is still high after reset is released, a fresh drain starts from address 0.

Test Plan:
1. Z[i]=3*i+1, m_ready=1, done rises at cycle 0:
   - 64 consecutive beats with values 1,4,...,190 in cycles 3..66.
   - m_last only on value 190.
   - drain_done pulses in cycle 67; busy falls with it.
2. Z[i]=i, m_ready toggling 1,0,1,0 then a 30% random-low pattern:
   - Output is exactly 0..63 in order, no duplicates.
   - m_data stable on every stalled cycle.
   - (z_rd_addr - accepted beats) <= 2 at all times.
3. m_ready held low for 20 cycles after done:
   - Exactly two reads issued (z_rd_addr reaches 2 and holds).
   - m_valid=1 with m_data=Z[0] throughout the stall.
   - Releasing m_ready gives 64 beats correctly.
4. done held high 200 cycles after drain_done:
   - No second drain (m_valid stays 0).
   - done low for 1 cycle then high again: a second full 64-beat drain of the same data.
5. Reset asserted for 1 cycle after beat 30 transfers, done kept high:
   - m_valid=0 the cycle after reset.
   - After release, the drain restarts with beat value Z[0], 64 beats total.
6. Z[i]=32'hFFFFFFFF-i, MATRIX_SIZE=2, random m_ready:
   - Exactly beats FFFFFFFF then FFFFFFFE, with m_last on the second.
   - drain_done pulses once.
